// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch lap logger.
//   FIELD_W     : width of one displayed field (binary 0..99 fits in 8 bits)
//   VIEW_*      : view_mode encodings for the display selector
//   time_t      : packed {left, right}; left occupies the high bits so a plain
//                 relational compare on time_t orders times correctly
//   time_inc()  : one centisecond step with per-field terminal values
package stopwatch_pkg;

    localparam int unsigned FIELD_W = 8;

    localparam logic [1:0] VIEW_LIVE = 2'd0;
    localparam logic [1:0] VIEW_MIN  = 2'd1;
    localparam logic [1:0] VIEW_MAX  = 2'd2;
    localparam logic [1:0] VIEW_LAP  = 2'd3;

    typedef struct packed {
        logic [FIELD_W-1:0] left;
        logic [FIELD_W-1:0] right;
    } time_t;

    // Fast field rolls into the slow field; both wrap together at max:max.
    function automatic time_t time_inc(time_t t, int unsigned right_max,
                                       int unsigned left_max);
        time_t r;
        r = t;
        if (t.right == FIELD_W'(right_max)) begin
            r.right = '0;
            if (t.left == FIELD_W'(left_max)) begin
                r.left = '0;
            end else begin
                r.left = t.left + FIELD_W'(1);
            end
        end else begin
            r.right = t.right + FIELD_W'(1);
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_logger_if.sv
// Control/display bundle between the pulse layer and the stopwatch core.
//   master : pulse/view source (button layer or testbench)
//   slave  : stopwatch core
// Inputs to the core: start_stop_p, clear_p, lap_p, hist_clr_p (one-cycle
// pulses), view_mode, view_idx. Outputs: disp_left, disp_right, running,
// lap_count, lap_valid.
interface stopwatch_lap_logger_if #(
    parameter int unsigned IDX_W = 3
);
    import stopwatch_pkg::*;

    logic                start_stop_p;
    logic                clear_p;
    logic                lap_p;
    logic                hist_clr_p;
    logic [1:0]          view_mode;
    logic [IDX_W-1:0]    view_idx;
    logic [FIELD_W-1:0]  disp_left;
    logic [FIELD_W-1:0]  disp_right;
    logic                running;
    logic [IDX_W:0]      lap_count;
    logic                lap_valid;

    modport master (
        output start_stop_p, clear_p, lap_p, hist_clr_p, view_mode, view_idx,
        input  disp_left, disp_right, running, lap_count, lap_valid
    );

    modport slave (
        input  start_stop_p, clear_p, lap_p, hist_clr_p, view_mode, view_idx,
        output disp_left, disp_right, running, lap_count, lap_valid
    );

endinterface

// File: rtl/sw_tick_divider.sv
// Prescaler: counts 0..TICK_DIV-1 while enabled and flags the terminal count.
//   clk, rst_n : clock, async active-low reset
//   en         : count enable; when low the count is frozen, not cleared
//   clr        : synchronous clear to 0 (takes priority over en)
//   tick       : high during the cycle the count sits at TICK_DIV-1 while enabled
module sw_tick_divider #(
    parameter int unsigned TICK_DIV = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] TERM = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             at_term;

    assign at_term = (cnt_q == TERM);
    // Raw tick; the consumer decides how a same-cycle clear interacts with it.
    assign tick    = en & at_term;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = at_term ? '0 : cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/stopwatch_lap_logger.sv
// Run/stop centisecond stopwatch with a circular lap history and running
// min/max lap tracking, feeding a two-field binary display.
//   clk, rst_n : clock, async active-low reset (sync release upstream)
//   bus        : slave side of stopwatch_lap_logger_if
//                pulses start_stop_p/clear_p/lap_p/hist_clr_p, view_mode,
//                view_idx in; disp_left/disp_right (registered), running,
//                lap_count, lap_valid out
// LAP_DEPTH must be a power of two so the history pointers wrap naturally.
module stopwatch_lap_logger
    import stopwatch_pkg::*;
#(
    parameter int unsigned TICK_DIV  = 500000,
    parameter int unsigned RIGHT_MAX = 99,
    parameter int unsigned LEFT_MAX  = 99,
    parameter int unsigned LAP_DEPTH = 8,
    parameter int unsigned IDX_W     = $clog2(LAP_DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    stopwatch_lap_logger_if.slave  bus
);

    localparam logic [IDX_W:0] COUNT_MAX = (IDX_W + 1)'(LAP_DEPTH);

    logic             run_q;
    logic             tick;
    time_t            live_q, live_d;
    logic [IDX_W-1:0] wr_ptr_q;
    logic [IDX_W:0]   count_q;
    logic             valid_q;
    time_t            min_q, max_q;
    time_t            lap_mem [LAP_DEPTH];
    logic             lap_we;
    logic [IDX_W-1:0] rd_ptr;
    time_t            disp_d, disp_q;

    // ---------------------------------------------------------------- run state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else if (bus.start_stop_p) begin
            run_q <= ~run_q;
        end
    end

    sw_tick_divider #(
        .TICK_DIV (TICK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (run_q),
        .clr   (bus.clear_p),
        .tick  (tick)
    );

    // ---------------------------------------------------------------- live time
    always_comb begin
        live_d = live_q;
        if (bus.clear_p) begin
            live_d = '0;
        end else if (tick) begin
            live_d = time_inc(live_q, RIGHT_MAX, LEFT_MAX);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            live_q <= '0;
        end else begin
            live_q <= live_d;
        end
    end

    // ---------------------------------------------------------------- lap history
    // A history clear drops any lap requested in the same cycle.
    assign lap_we = bus.lap_p & ~bus.hist_clr_p;

    // Storage needs no reset: count_q gates every read.
    always_ff @(posedge clk) begin
        if (lap_we) begin
            lap_mem[wr_ptr_q] <= live_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            min_q    <= '0;
            max_q    <= '0;
        end else if (bus.hist_clr_p) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
            min_q    <= '0;
            max_q    <= '0;
        end else if (lap_we) begin
            wr_ptr_q <= wr_ptr_q + IDX_W'(1);
            if (count_q != COUNT_MAX) begin
                count_q <= count_q + (IDX_W + 1)'(1);
            end
            valid_q <= 1'b1;
            // Min/max span all laps since the history clear, even overwritten ones.
            if (!valid_q || (live_q < min_q)) begin
                min_q <= live_q;
            end
            if (!valid_q || (live_q > max_q)) begin
                max_q <= live_q;
            end
        end
    end

    // ---------------------------------------------------------------- display
    // view_idx 0 is the newest entry, i.e. one behind the write pointer.
    assign rd_ptr = wr_ptr_q - IDX_W'(1) - bus.view_idx;

    always_comb begin
        disp_d = '0;
        case (bus.view_mode)
            VIEW_LIVE: disp_d = live_q;
            VIEW_MIN: begin
                if (valid_q) begin
                    disp_d = min_q;
                end
            end
            VIEW_MAX: begin
                if (valid_q) begin
                    disp_d = max_q;
                end
            end
            default: begin
                if ({1'b0, bus.view_idx} < count_q) begin
                    disp_d = lap_mem[rd_ptr];
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            disp_q <= '0;
        end else begin
            disp_q <= disp_d;
        end
    end

    assign bus.disp_left  = disp_q.left;
    assign bus.disp_right = disp_q.right;
    assign bus.running    = run_q;
    assign bus.lap_count  = count_q;
    assign bus.lap_valid  = valid_q;

endmodule

// File: tb/tb_stopwatch_lap_logger.sv
// Directed bench for stopwatch_lap_logger. Stimulus pushes the expected
// {running, lap_valid, lap_count, left, right} into a scoreboard and raises a
// sample request; a separate monitor pops and compares on the falling edge.
module tb_stopwatch_lap_logger;
    import stopwatch_pkg::*;

    localparam int unsigned TICK_DIV  = 4;
    localparam int unsigned LAP_DEPTH = 8;
    localparam int unsigned IDX_W     = 3;

    typedef struct {
        string       name;
        logic [21:0] exp;
    } exp_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic chk_req = 1'b0;
    exp_t sb [$];
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    stopwatch_lap_logger_if #(.IDX_W(IDX_W)) bus ();

    stopwatch_lap_logger #(
        .TICK_DIV  (TICK_DIV),
        .RIGHT_MAX (99),
        .LEFT_MAX  (99),
        .LAP_DEPTH (LAP_DEPTH),
        .IDX_W     (IDX_W)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ------------------------------------------------------------ monitor
    exp_t        mon_e;
    logic [21:0] mon_act;

    always @(negedge clk) begin
        if (chk_req) begin
            mon_act = {bus.running, bus.lap_valid, bus.lap_count,
                       bus.disp_left, bus.disp_right};
            n_tests++;
            if (sb.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_underflow: sample requested with empty queue");
            end else begin
                mon_e = sb.pop_front();
                if (mon_act !== mon_e.exp) begin
                    n_fail++;
                    $display("FAIL %s: got run=%0d valid=%0d count=%0d disp=%0d:%0d, want run=%0d valid=%0d count=%0d disp=%0d:%0d",
                             mon_e.name, mon_act[21], mon_act[20], mon_act[19:16],
                             mon_act[15:8], mon_act[7:0], mon_e.exp[21], mon_e.exp[20],
                             mon_e.exp[19:16], mon_e.exp[15:8], mon_e.exp[7:0]);
                end
            end
        end
    end

    // ------------------------------------------------------------ stimulus helpers
    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // 0 start_stop, 1 clear, 2 lap, 3 hist_clr
    task automatic pulse(input int which);
        case (which)
            0: bus.start_stop_p = 1'b1;
            1: bus.clear_p      = 1'b1;
            2: bus.lap_p        = 1'b1;
            default: bus.hist_clr_p = 1'b1;
        endcase
        cyc(1);
        bus.start_stop_p = 1'b0;
        bus.clear_p      = 1'b0;
        bus.lap_p        = 1'b0;
        bus.hist_clr_p   = 1'b0;
    endtask

    task automatic check(input string name, input bit run, input bit vld,
                         input int cnt, input int l, input int r);
        exp_t e;
        e.name = name;
        e.exp  = {run, vld, 4'(cnt), 8'(l), 8'(r)};
        sb.push_back(e);
        chk_req = 1'b1;
        cyc(1);
        chk_req = 1'b0;
    endtask

    task automatic view(input int mode, input int idx);
        bus.view_mode = 2'(mode);
        bus.view_idx  = 3'(idx);
        cyc(1);
    endtask

    // Clear, then run exactly k ticks and stop with the prescaler back at 0.
    task automatic run_ticks(input int k);
        pulse(1);
        pulse(0);
        cyc(TICK_DIV * k - 1);
        pulse(0);
    endtask

    // ------------------------------------------------------------ sequence
    initial begin
        bus.start_stop_p = 1'b0;
        bus.clear_p      = 1'b0;
        bus.lap_p        = 1'b0;
        bus.hist_clr_p   = 1'b0;
        bus.view_mode    = VIEW_LIVE;
        bus.view_idx     = '0;

        cyc(2);
        check("reset_state", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        cyc(1);

        // 400 running cycles at TICK_DIV=4 -> 100 ticks -> 1:00
        pulse(0);
        check("run_started", 1, 0, 0, 0, 0);
        cyc(398);
        pulse(0);
        cyc(1);
        check("live_1_00", 0, 0, 0, 1, 0);
        cyc(200);
        check("stop_hold", 0, 0, 0, 1, 0);

        // 9998 ticks -> 99:98, then one tick each to 99:99 and wrap to 0:0
        pulse(1);
        pulse(0);
        cyc(39991);
        pulse(0);
        cyc(1);
        check("preload_99_98", 0, 0, 0, 99, 98);
        pulse(0);
        cyc(3);
        pulse(0);
        cyc(1);
        check("tick_99_99", 0, 0, 0, 99, 99);
        pulse(0);
        cyc(3);
        pulse(0);
        cyc(1);
        check("wrap_0_0", 0, 0, 0, 0, 0);

        // Laps 0:50, 1:10, 0:05
        run_ticks(50);
        pulse(2);
        run_ticks(110);
        pulse(2);
        run_ticks(5);
        pulse(2);
        view(1, 0);
        check("min_3laps", 0, 1, 3, 0, 5);
        view(2, 0);
        check("max_3laps", 0, 1, 3, 1, 10);
        view(3, 0);
        check("idx0_newest", 0, 1, 3, 0, 5);
        view(3, 2);
        check("idx2_oldest", 0, 1, 3, 0, 50);
        view(3, 3);
        check("idx3_empty", 0, 1, 3, 0, 0);
        view(0, 0);
        check("live_0_05", 0, 1, 3, 0, 5);

        // History clear, then 10 laps of 0:01..0:10 into 8 slots
        pulse(3);
        view(1, 0);
        check("hist_clr_min", 0, 0, 0, 0, 0);
        for (int i = 1; i <= 10; i++) begin
            run_ticks(i);
            pulse(2);
        end
        view(3, 7);
        check("full_idx7", 0, 1, 8, 0, 3);
        view(3, 0);
        check("full_idx0", 0, 1, 8, 0, 10);
        view(1, 0);
        check("min_overwritten", 0, 1, 8, 0, 1);
        view(2, 0);
        check("max_full", 0, 1, 8, 0, 10);

        // Lap in the same cycle as the 0:07 -> 0:08 tick
        pulse(1);
        pulse(0);
        cyc(31);
        pulse(2);
        pulse(0);
        view(3, 0);
        check("lap_on_tick", 0, 1, 8, 0, 7);
        view(0, 0);
        check("live_after_tick", 0, 1, 8, 0, 8);

        // History clear beats a same-cycle lap
        bus.hist_clr_p = 1'b1;
        bus.lap_p      = 1'b1;
        cyc(1);
        bus.hist_clr_p = 1'b0;
        bus.lap_p      = 1'b0;
        view(1, 0);
        check("hist_beats_lap", 0, 0, 0, 0, 0);
        view(3, 0);
        check("hist_idx0", 0, 0, 0, 0, 0);

        // Clear+start together both act; clear then beats a tick
        view(0, 0);
        bus.clear_p      = 1'b1;
        bus.start_stop_p = 1'b1;
        cyc(1);
        bus.clear_p      = 1'b0;
        bus.start_stop_p = 1'b0;
        check("clr_start_both", 1, 0, 0, 0, 8);  // display lags live by a cycle
        cyc(2);
        pulse(1);
        pulse(0);
        cyc(1);
        check("clear_beats_tick", 0, 0, 0, 0, 0);

        // Asynchronous reset mid-run with a lap stored
        run_ticks(3);
        pulse(2);
        view(3, 0);
        check("pre_reset_lap", 0, 1, 1, 0, 3);
        pulse(0);
        cyc(10);
        rst_n = 1'b0;
        check("async_reset", 0, 0, 0, 0, 0);
        rst_n = 1'b1;
        view(0, 0);
        pulse(0);
        cyc(7);
        pulse(0);
        cyc(1);
        check("restart_0_02", 0, 0, 0, 0, 2);

        cyc(2);
        n_tests++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending entries, want 0", sb.size());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
